mux8_rr_arbiter: RTL and testbench

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_rr_arbiter_pkg.sv | 39 +++
 rtl/mux8_rr_arbiter_mux8x1.sv | 26 ++
 rtl/mux8_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared sizes, state encoding and the round-robin pick helper for the
// 8-way shared-line arbiter.
package mux8_rr_arbiter_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Rotate so bit 0 is the requester just after ptr, take the lowest set
    // bit, then undo the rotation. Result is {found, winner index}.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [N_REQ-1:0] req_v,
        input logic [SEL_W-1:0] ptr_v
    );
        logic [2*N_REQ-1:0] dbl_v;
        logic [N_REQ-1:0]   rot_v;
        logic [SEL_W:0]     shamt_v;
        logic [SEL_W-1:0]   off_v;
        logic [SEL_W-1:0]   idx_v;
        dbl_v   = {req_v, req_v};
        shamt_v = {1'b0, ptr_v} + 4'd1;
        rot_v   = N_REQ'(dbl_v >> shamt_v);
        off_v   = 3'd0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot_v[j]) begin
                off_v = SEL_W'(j);
            end
        end
        idx_v = ptr_v + 3'd1 + off_v;
        return {|rot_v, idx_v};
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux8x1.sv
// Existing 8:1 single-bit mux, built as a three-level tree of 2:1 cells.
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux8x1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);
    logic [3:0] lvl0_s;
    logic [1:0] lvl1_s;

    mux2x1 u_m00 (.a(in[0]), .b(in[1]), .s(sel[0]), .y(lvl0_s[0]));
    mux2x1 u_m01 (.a(in[2]), .b(in[3]), .s(sel[0]), .y(lvl0_s[1]));
    mux2x1 u_m02 (.a(in[4]), .b(in[5]), .s(sel[0]), .y(lvl0_s[2]));
    mux2x1 u_m03 (.a(in[6]), .b(in[7]), .s(sel[0]), .y(lvl0_s[3]));
    mux2x1 u_m10 (.a(lvl0_s[0]), .b(lvl0_s[1]), .s(sel[1]), .y(lvl1_s[0]));
    mux2x1 u_m11 (.a(lvl0_s[2]), .b(lvl0_s[3]), .s(sel[1]), .y(lvl1_s[1]));
    mux2x1 u_m20 (.a(lvl1_s[0]), .b(lvl1_s[1]), .s(sel[2]), .y(out));
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbitration for a single shared data line with a bounded
// hold time; the owner's data bit is routed through an 8:1 mux.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state_r, state_n_s;
    logic [N_REQ-1:0]  gnt_r, gnt_n_s;
    logic [SEL_W-1:0]  sel_r, sel_n_s;
    logic [SEL_W-1:0]  ptr_r, ptr_n_s;
    logic [HOLD_W-1:0] hold_r, hold_n_s;
    logic              busy_r, busy_n_s;
    logic              timeout_r, timeout_n_s;
    logic [SEL_W:0]    pick_s;

    assign pick_s = rr_pick(req, ptr_r);

    // Next-state and next-output decode for the IDLE/GRANT/GAP controller
    always_comb begin
        state_n_s   = state_r;
        gnt_n_s     = gnt_r;
        sel_n_s     = sel_r;
        ptr_n_s     = ptr_r;
        hold_n_s    = hold_r;
        busy_n_s    = busy_r;
        timeout_n_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s[SEL_W]) begin
                    state_n_s = GRANT;
                    gnt_n_s   = 8'd1 << pick_s[SEL_W-1:0];
                    sel_n_s   = pick_s[SEL_W-1:0];
                    ptr_n_s   = pick_s[SEL_W-1:0];
                    busy_n_s  = 1'b1;
                    hold_n_s  = 9'd1;
                end else begin
                    gnt_n_s  = 8'd0;
                    busy_n_s = 1'b0;
                end
            end
            GRANT: begin
                if (req[sel_r] && (hold_r < MAX_HOLD_C)) begin
                    hold_n_s = hold_r + 9'd1;
                end else begin
                    // Release wins over the limit when both happen together
                    state_n_s   = GAP;
                    gnt_n_s     = 8'd0;
                    busy_n_s    = 1'b0;
                    hold_n_s    = 9'd0;
                    timeout_n_s = req[sel_r];
                end
            end
            GAP: begin
                state_n_s = IDLE;
                gnt_n_s   = 8'd0;
                busy_n_s  = 1'b0;
            end
            default: begin
                state_n_s = IDLE;
                gnt_n_s   = 8'd0;
                busy_n_s  = 1'b0;
                hold_n_s  = 9'd0;
            end
        endcase
    end

    // Controller state and registered outputs; ptr resets to 7 so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= 8'd0;
            sel_r     <= 3'd0;
            ptr_r     <= 3'd7;
            hold_r    <= 9'd0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            gnt_r     <= gnt_n_s;
            sel_r     <= sel_n_s;
            ptr_r     <= ptr_n_s;
            hold_r    <= hold_n_s;
            busy_r    <= busy_n_s;
            timeout_r <= timeout_n_s;
        end
    end

    assign gnt     = gnt_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

    mux8x1 u_mux (
        .in  (din),
        .sel (sel_r),
        .out (dout)
    );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a short hold limit so the timeout
// paths are reachable in a few cycles.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       dout;
    logic       busy;
    logic       timeout;

    int n_checks;
    int n_pass;

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .dout    (dout),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Check grant, select, busy and timeout together after an edge.
    task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                             input logic b, input logic t);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(g));
        check_eq({tag, ".sel"}, 32'(sel), 32'(s));
        check_eq({tag, ".busy"}, 32'(busy), 32'(b));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] idx;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        req = 8'h00;
        din = 8'h00;
        tick();
        tick();
        check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester 0: grant one cycle later, release through GAP/IDLE
        req = 8'h01;
        tick();
        check_out("r0_grant", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_out("r0_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_out("r0_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_out("r0_stay_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // All requesting, each owner releases after 3 cycles: order 0..7,0
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            idx = 3'(k);
            tick();
            check_out($sformatf("rr%0d_grant", k), 8'd1 << idx, idx, 1'b1, 1'b0);
            tick();
            tick();
            check_eq($sformatf("rr%0d_hold", k), 32'(gnt), 32'(8'd1 << idx));
            req = 8'hFF & ~(8'd1 << idx);
            tick();
            check_out($sformatf("rr%0d_gap", k), 8'h00, idx, 1'b0, 1'b0);
            req = 8'hFF;
            tick();
            check_eq($sformatf("rr%0d_idle", k), 32'(gnt), 32'h0);
        end
        req = 8'h00;
        tick();
        tick();

        // Requester 3 held past the limit: 4 grant cycles, timeout, re-grant
        req = 8'h08;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out($sformatf("to3_c%0d", k), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        tick();
        check_out("to3_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
        tick();
        check_out("to3_idle", 8'h00, 3'd3, 1'b0, 1'b0);
        tick();
        check_out("to3_regrant", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        tick();

        // Requesters 2 and 3: 2 times out and must yield to 3
        req = 8'h0C;
        tick();
        check_out("to2_grant", 8'h04, 3'd2, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_eq("to2_last", 32'(gnt), 32'h04);
        tick();
        check_out("to2_pulse", 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        check_eq("to2_idle_to", 32'(timeout), 32'h0);
        tick();
        check_out("to2_next3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        tick();

        // Release on the very cycle the limit is reached: no timeout
        req = 8'h01;
        tick();
        check_out("lim_grant", 8'h01, 3'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_eq("lim_c4", 32'(gnt), 32'h01);
        req = 8'h00;
        tick();
        check_out("lim_release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();

        // Data path follows the selected owner
        din = 8'b1010_0000;
        req = 8'h20;
        tick();
        check_eq("mux5_sel", 32'(sel), 32'd5);
        check_eq("mux5_dout", 32'(dout), 32'd1);
        req = 8'h00;
        tick();
        tick();
        req = 8'h40;
        tick();
        check_eq("mux6_sel", 32'(sel), 32'd6);
        check_eq("mux6_dout", 32'(dout), 32'd0);
        req = 8'h00;
        tick();
        check_eq("mux6_gap_sel", 32'(sel), 32'd6);
        din = 8'h40;
        #1;
        check_eq("mux6_track_hi", 32'(dout), 32'd1);
        din = 8'h00;
        #1;
        check_eq("mux6_track_lo", 32'(dout), 32'd0);
        tick();

        // Reset mid-grant to 4: immediate drop, then 0 wins over 4
        req = 8'h10;
        tick();
        check_out("rst4_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("rst4_async", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h11;
        tick();
        rst = 1'b0;
        check_out("rst4_held", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_out("rst4_next0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_eq("rst4_no_to", 32'(timeout), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
